// File: rtl/mbscore_rf_wr_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : mbscore_rf_wr_arb_if
//  Description : Bundle of the requester, scoreboard and register-file write
//                signals around the MBScore GPR write-port arbiter.
//                master = execute/memory/decode side, slave = arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mbscore_rf_wr_arb_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_lui;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;

    logic              link_valid;
    logic              link_ready;
    logic [DATA_W-1:0] link_pc;

    logic              ld_issue;
    logic [ADDR_W-1:0] ld_rd;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              hazard;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic [1:0]        grant_src;

    modport master (
        output alu_valid, alu_rd, alu_data, alu_lui,
        output mem_valid, mem_rd, mem_data,
        output link_valid, link_pc,
        output ld_issue, ld_rd, rs_addr, rt_addr,
        input  alu_ready, mem_ready, link_ready, hazard,
        input  rf_we, rf_addr, rf_wdata, grant_src
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, alu_lui,
        input  mem_valid, mem_rd, mem_data,
        input  link_valid, link_pc,
        input  ld_issue, ld_rd, rs_addr, rt_addr,
        output alu_ready, mem_ready, link_ready, hazard,
        output rf_we, rf_addr, rf_wdata, grant_src
    );
endinterface
`default_nettype wire

// File: rtl/mbscore_rf_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mbscore_rf_wr_arb
//  Description : Shares the single GPR write port between ALU write-back,
//                queued load returns and link writes; keeps a scoreboard of
//                outstanding load destinations for decode hazard detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module mbscore_rf_wr_arb #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int MQ_DEPTH   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    mbscore_rf_wr_arb_if.slave  bus
);

    localparam int c_mq_aw  = $clog2(MQ_DEPTH);
    localparam int c_ptr_w  = c_mq_aw + 1;
    localparam int c_cnt_w  = $clog2(STARVE_MAX + 1);
    localparam int c_nregs  = 2 ** ADDR_W;

    localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_MAX);

    localparam logic [1:0] c_src_none = 2'd0;
    localparam logic [1:0] c_src_alu  = 2'd1;
    localparam logic [1:0] c_src_mem  = 2'd2;
    localparam logic [1:0] c_src_link = 2'd3;

    // Memory-return queue
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [ADDR_W-1:0]  r_mq_rd   [MQ_DEPTH];
    logic [DATA_W-1:0]  r_mq_data [MQ_DEPTH];
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic [ADDR_W-1:0]  w_head_rd;
    logic [DATA_W-1:0]  w_head_data;

    // Arbitration
    logic [c_cnt_w-1:0] r_starve_cnt;
    logic               w_promote;
    logic [1:0]         w_grant_src;
    logic [ADDR_W-1:0]  w_wr_addr;
    logic [DATA_W-1:0]  w_wr_data;
    logic [DATA_W-1:0]  w_alu_data;
    logic [DATA_W-1:0]  w_link_data;

    // Scoreboard
    logic [c_nregs-1:0] r_busy;
    logic [c_nregs-1:0] w_busy_nxt;

    // Write-port registers
    logic               r_rf_we;
    logic [ADDR_W-1:0]  r_rf_addr;
    logic [DATA_W-1:0]  r_rf_wdata;
    logic [1:0]         r_grant_src;

    // Extra pointer bit separates full from empty when the index bits match
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_ptr_w-1] != r_rd_ptr[c_ptr_w-1]) &&
                     (r_wr_ptr[c_mq_aw-1:0] == r_rd_ptr[c_mq_aw-1:0]);

    assign w_head_rd   = r_mq_rd[r_rd_ptr[c_mq_aw-1:0]];
    assign w_head_data = r_mq_data[r_rd_ptr[c_mq_aw-1:0]];

    // A full queue refuses pushes even when it pops in the same cycle
    assign w_push        = bus.mem_valid && !w_full && !rst;
    assign w_pop         = (w_grant_src == c_src_mem);
    assign bus.mem_ready = !w_full;

    assign w_alu_data  = bus.alu_lui ? (bus.alu_data << 16) : bus.alu_data;
    assign w_link_data = bus.link_pc + DATA_W'(4);
    assign w_promote   = (r_starve_cnt == c_starve_max);

    // Priority select: LINK > MEM > ALU, or ALU first once it has starved
    always_comb begin
        w_grant_src = c_src_none;
        w_wr_addr   = '0;
        w_wr_data   = '0;
        if (!rst) begin
            if (w_promote && bus.alu_valid) begin
                w_grant_src = c_src_alu;
                w_wr_addr   = bus.alu_rd;
                w_wr_data   = w_alu_data;
            end else if (bus.link_valid) begin
                w_grant_src = c_src_link;
                w_wr_addr   = {ADDR_W{1'b1}};
                w_wr_data   = w_link_data;
            end else if (!w_empty) begin
                w_grant_src = c_src_mem;
                w_wr_addr   = w_head_rd;
                w_wr_data   = w_head_data;
            end else if (bus.alu_valid) begin
                w_grant_src = c_src_alu;
                w_wr_addr   = bus.alu_rd;
                w_wr_data   = w_alu_data;
            end
        end
    end

    assign bus.alu_ready  = (w_grant_src == c_src_alu);
    assign bus.link_ready = (w_grant_src == c_src_link);

    // Queue storage; contents are qualified by the pointers so no reset needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mq_rd[r_wr_ptr[c_mq_aw-1:0]]   <= bus.mem_rd;
            r_mq_data[r_wr_ptr[c_mq_aw-1:0]] <= bus.mem_data;
        end
    end

    // Queue pointers, wrapping naturally through the extra bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
        end
    end

    // Count consecutive ALU losses, saturating at the promotion threshold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (!bus.alu_valid || bus.alu_ready) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != c_starve_max) begin
            r_starve_cnt <= r_starve_cnt + c_cnt_w'(1);
        end
    end

    // Clear on load write-back, then set on issue so a same-cycle set wins
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop) w_busy_nxt[w_head_rd] = 1'b0;
        if (bus.ld_issue && (bus.ld_rd != '0)) w_busy_nxt[bus.ld_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (rst) r_busy <= '0;
        else     r_busy <= w_busy_nxt;
    end

    assign bus.hazard = !rst && (r_busy[bus.rs_addr] || r_busy[bus.rt_addr]);

    // Register the winning write; writes to r0 are consumed but not enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_we     <= 1'b0;
            r_rf_addr   <= '0;
            r_rf_wdata  <= '0;
            r_grant_src <= c_src_none;
        end else begin
            r_rf_we     <= (w_grant_src != c_src_none) && (w_wr_addr != '0);
            r_rf_addr   <= w_wr_addr;
            r_rf_wdata  <= w_wr_data;
            r_grant_src <= w_grant_src;
        end
    end

    assign bus.rf_we     = r_rf_we;
    assign bus.rf_addr   = r_rf_addr;
    assign bus.rf_wdata  = r_rf_wdata;
    assign bus.grant_src = r_grant_src;

endmodule
`default_nettype wire

// File: tb/tb_mbscore_rf_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mbscore_rf_wr_arb
//  Description : Directed self-checking bench for the GPR write-port arbiter
//                and load scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mbscore_rf_wr_arb;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mbscore_rf_wr_arb_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    mbscore_rf_wr_arb #(
        .ADDR_W     (5),
        .DATA_W     (32),
        .MQ_DEPTH   (2),
        .STARVE_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.alu_valid  = 1'b0;
        bus.alu_rd     = '0;
        bus.alu_data   = '0;
        bus.alu_lui    = 1'b0;
        bus.mem_valid  = 1'b0;
        bus.mem_rd     = '0;
        bus.mem_data   = '0;
        bus.link_valid = 1'b0;
        bus.link_pc    = '0;
        bus.ld_issue   = 1'b0;
        bus.ld_rd      = '0;
        bus.rs_addr    = '0;
        bus.rt_addr    = '0;
    endtask

    task automatic port(input string tag, input logic we, input logic [4:0] addr,
                        input logic [31:0] data, input logic [1:0] src);
        chk({tag, "_we"},   32'(bus.rf_we),     32'(we));
        chk({tag, "_addr"}, 32'(bus.rf_addr),   32'(addr));
        chk({tag, "_data"}, bus.rf_wdata,       data);
        chk({tag, "_src"},  32'(bus.grant_src), 32'(src));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // ---- Reset with requests pending: everything ignored ----
        clr();
        rst = 1'b1;
        bus.alu_valid  = 1'b1;
        bus.link_valid = 1'b1;
        bus.mem_valid  = 1'b1;
        bus.ld_issue   = 1'b1;
        bus.ld_rd      = 5'd4;
        bus.rs_addr    = 5'd4;
        tick();
        tick();
        port("rst", 1'b0, 5'd0, 32'h0, 2'd0);
        chk("rst_mem_ready",  32'(bus.mem_ready),  32'd1);
        chk("rst_hazard",     32'(bus.hazard),     32'd0);
        chk("rst_alu_ready",  32'(bus.alu_ready),  32'd0);
        chk("rst_link_ready", 32'(bus.link_ready), 32'd0);
        clr();
        rst = 1'b0;
        bus.rs_addr = 5'd4;
        tick();
        chk("post_rst_we",     32'(bus.rf_we),     32'd0);
        chk("post_rst_hazard", 32'(bus.hazard),    32'd0);
        chk("post_rst_mready", 32'(bus.mem_ready), 32'd1);
        clr();

        // ---- ALU only, LUI form ----
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 32'h0000_1234;
        bus.alu_lui   = 1'b1;
        #1;
        chk("alu_ready", 32'(bus.alu_ready), 32'd1);
        tick();
        clr();
        port("alu_lui", 1'b1, 5'd5, 32'h1234_0000, 2'd1);
        tick();
        chk("alu_one_cycle_we",  32'(bus.rf_we),     32'd0);
        chk("alu_one_cycle_src", 32'(bus.grant_src), 32'd0);

        // ---- ALU and LINK together: LINK first, ALU next ----
        bus.alu_valid  = 1'b1;
        bus.alu_rd     = 5'd9;
        bus.alu_data   = 32'hDEAD_BEEF;
        bus.link_valid = 1'b1;
        bus.link_pc    = 32'h0000_0100;
        #1;
        chk("contest_link_ready", 32'(bus.link_ready), 32'd1);
        chk("contest_alu_ready",  32'(bus.alu_ready),  32'd0);
        tick();
        bus.link_valid = 1'b0;
        port("link", 1'b1, 5'd31, 32'h0000_0104, 2'd3);
        #1;
        chk("alu_after_link_ready", 32'(bus.alu_ready), 32'd1);
        tick();
        clr();
        port("alu_after_link", 1'b1, 5'd9, 32'hDEAD_BEEF, 2'd1);

        // ---- Link PC wraps modulo 2^32 ----
        bus.link_valid = 1'b1;
        bus.link_pc    = 32'hFFFF_FFFC;
        tick();
        clr();
        port("link_wrap", 1'b1, 5'd31, 32'h0000_0000, 2'd3);

        // ---- ALU write to r0: consumed, no write enable ----
        bus.alu_valid = 1'b1;
        bus.alu_data  = 32'h5555_AAAA;
        #1;
        chk("r0_alu_ready", 32'(bus.alu_ready), 32'd1);
        tick();
        clr();
        chk("r0_we",  32'(bus.rf_we),     32'd0);
        chk("r0_src", 32'(bus.grant_src), 32'd1);

        // ---- ld_rd = 0 never raises hazard ----
        bus.ld_issue = 1'b1;
        bus.ld_rd    = 5'd0;
        tick();
        clr();
        #1;
        chk("ld_r0_hazard", 32'(bus.hazard), 32'd0);

        // ---- Load scoreboard on r7 ----
        bus.ld_issue = 1'b1;
        bus.ld_rd    = 5'd7;
        bus.rs_addr  = 5'd7;
        #1;
        chk("ld7_hazard_issue_cycle", 32'(bus.hazard), 32'd0);
        tick();
        bus.ld_issue = 1'b0;
        #1;
        chk("ld7_hazard_set", 32'(bus.hazard), 32'd1);
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd7;
        bus.mem_data  = 32'hAAAA_5555;
        tick();
        bus.mem_valid = 1'b0;
        #1;
        chk("ld7_hazard_grant_cycle", 32'(bus.hazard), 32'd1);
        chk("ld7_we_before", 32'(bus.rf_we), 32'd0);
        tick();
        port("ld7", 1'b1, 5'd7, 32'hAAAA_5555, 2'd2);
        chk("ld7_hazard_clear", 32'(bus.hazard), 32'd0);
        clr();

        // ---- Set and clear of r8 in the same cycle: set wins ----
        bus.ld_issue = 1'b1;
        bus.ld_rd    = 5'd8;
        tick();
        clr();
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd8;
        bus.mem_data  = 32'h0000_0088;
        tick();
        clr();
        bus.ld_issue = 1'b1;
        bus.ld_rd    = 5'd8;
        tick();
        clr();
        bus.rt_addr = 5'd8;
        #1;
        port("ld8", 1'b1, 5'd8, 32'h0000_0088, 2'd2);
        chk("setwins_hazard", 32'(bus.hazard), 32'd1);
        clr();

        // ---- Starvation: MEM kept non-empty, ALU promoted on 5th cycle ----
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd3;
        bus.mem_data  = 32'h0000_0033;
        tick();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd10;
        bus.alu_data  = 32'h0000_000A;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk($sformatf("starve_loss%0d", i), 32'(bus.alu_ready), 32'd0);
            tick();
        end
        bus.mem_valid = 1'b0;
        #1;
        chk("starve_promoted", 32'(bus.alu_ready), 32'd1);
        tick();
        port("starve_alu", 1'b1, 5'd10, 32'h0000_000A, 2'd1);
        chk("starve_cleared_mem_wins", 32'(bus.alu_ready), 32'd0);
        tick();
        clr();
        port("starve_mem_after", 1'b1, 5'd3, 32'h0000_0033, 2'd2);
        tick();

        // ---- FIFO full while LINK holds the port ----
        bus.link_valid = 1'b1;
        bus.link_pc    = 32'h0000_0200;
        bus.mem_valid  = 1'b1;
        bus.mem_rd     = 5'd11;
        bus.mem_data   = 32'h0000_00B1;
        #1;
        chk("full_ready_1", 32'(bus.mem_ready), 32'd1);
        tick();
        bus.mem_rd   = 5'd12;
        bus.mem_data = 32'h0000_00B2;
        #1;
        chk("full_ready_2", 32'(bus.mem_ready), 32'd1);
        tick();
        bus.mem_rd   = 5'd13;
        bus.mem_data = 32'h0000_00B3;
        #1;
        chk("full_ready_3", 32'(bus.mem_ready), 32'd0);
        tick();
        bus.link_valid = 1'b0;
        #1;
        chk("full_ready_pop_cycle", 32'(bus.mem_ready), 32'd0);
        tick();
        port("full_first", 1'b1, 5'd11, 32'h0000_00B1, 2'd2);
        chk("full_ready_after_pop", 32'(bus.mem_ready), 32'd1);
        tick();
        bus.mem_valid = 1'b0;
        port("full_second", 1'b1, 5'd12, 32'h0000_00B2, 2'd2);
        tick();
        port("full_third", 1'b1, 5'd13, 32'h0000_00B3, 2'd2);
        tick();
        chk("full_drained_we", 32'(bus.rf_we), 32'd0);
        clr();

        // ---- Reset mid-operation with queued loads and busy bits ----
        bus.link_valid = 1'b1;
        bus.link_pc    = 32'h0000_0300;
        bus.ld_issue   = 1'b1;
        bus.ld_rd      = 5'd14;
        bus.mem_valid  = 1'b1;
        bus.mem_rd     = 5'd14;
        bus.mem_data   = 32'h0000_00E0;
        tick();
        bus.ld_rd    = 5'd15;
        bus.mem_rd   = 5'd15;
        bus.mem_data = 32'h0000_00F0;
        tick();
        bus.ld_issue  = 1'b0;
        bus.mem_valid = 1'b0;
        bus.rs_addr   = 5'd14;
        bus.rt_addr   = 5'd15;
        #1;
        chk("pre_rst_full",   32'(bus.mem_ready), 32'd0);
        chk("pre_rst_hazard", 32'(bus.hazard),    32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_we",     32'(bus.rf_we),     32'd0);
        chk("mid_rst_src",    32'(bus.grant_src), 32'd0);
        chk("mid_rst_mready", 32'(bus.mem_ready), 32'd1);
        rst = 1'b0;
        bus.link_valid = 1'b0;
        #1;
        chk("mid_rst_hazard", 32'(bus.hazard), 32'd0);
        tick();
        tick();
        chk("post_mid_rst_we",     32'(bus.rf_we),     32'd0);
        chk("post_mid_rst_src",    32'(bus.grant_src), 32'd0);
        chk("post_mid_rst_hazard", 32'(bus.hazard),    32'd0);
        clr();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mbscore_rf_wr_arb.md
# mbscore_rf_wr_arb

Write-port arbiter and load scoreboard for the MBScore general register file. It shares the file's single GPR write port between three requesters: ALU write-back, buffered memory-load returns, and link (PC+4 to r31) writes. It registers the winning write onto the port and tracks outstanding load destinations so that decode can stall on read-after-load hazards. It sits between the execute/memory stages and the register file write inputs.

## Interface
- `ADDR_W`, 5, register address width
- `DATA_W`, 32, data width
- `MQ_DEPTH`, 2, memory-return queue depth (power of 2, ≥2)
- `STARVE_MAX`, 4, consecutive ALU losses before the ALU is promoted
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `alu_valid` / `alu_ready`  in/out  1  ALU write request handshake
- `alu_rd`  in  ADDR_W  ALU destination
- `alu_data`  in  DATA_W  ALU result
- `alu_lui`  in  1  write `{alu_data[15:0],16'h0}` instead of `alu_data`
- `mem_valid` / `mem_ready`  in/out  1  load-return handshake (push into queue)
- `mem_rd`  in  ADDR_W  load destination
- `mem_data`  in  DATA_W  load data
- `link_valid` / `link_ready`  in/out  1  link write request handshake
- `link_pc`  in  DATA_W  PC of the linking instruction
- `ld_issue`  in  1  load dispatched this cycle
- `ld_rd`  in  ADDR_W  its destination
- `rs_addr`, `rt_addr`  in  ADDR_W  decode source operands
- `hazard`  out  1  rs or rt has an outstanding load
- `rf_we`  out  1  register file write enable
- `rf_addr`  out  ADDR_W  write address
- `rf_wdata`  out  DATA_W  write data
- `grant_src`  out  2  source of the current `rf_*` write: 0 none, 1 ALU, 2 MEM, 3 LINK

## Operation
- Memory returns enter a FIFO of depth `MQ_DEPTH`. `mem_ready = !full`; it is a registered-state function only. When the FIFO is full, no push is accepted, even on a pop cycle.
- Arbitration runs each cycle over {LINK: `link_valid`, MEM: FIFO non-empty, ALU: `alu_valid`}. At most one grant per cycle.
- Default priority: LINK > MEM > ALU. When `starve_cnt == STARVE_MAX`, priority is ALU > LINK > MEM.
- `starve_cnt` behaviour:
  - increments, saturating at `STARVE_MAX`, when `alu_valid` is high and the ALU is not granted;
  - clears when the ALU is granted or `alu_valid` is low.
- `alu_ready` and `link_ready` are combinational grant indications. A MEM grant pops the FIFO head.
- Write data by source:
  - ALU: `alu_data`, or the LUI form when `alu_lui` is set.
  - MEM: head data.
  - LINK: `link_pc + 4` (mod 2^32) to address 31.
- A granted write whose address is 0 is consumed (handshake completes, FIFO pops) but produces `rf_we = 0`; `grant_src` still reports the source.
- Scoreboard: `busy[31:1]`, with r0 never busy.
  - `ld_issue` with `ld_rd != 0` sets `busy[ld_rd]`.
  - A MEM grant clears `busy[head_rd]`.
  - If a set and a clear of the same register occur in the same cycle, the set wins.
- `hazard = busy[rs_addr] | busy[rt_addr]`, combinational.

## Timing
- `rf_we`, `rf_addr`, `rf_wdata`, `grant_src` are registered: a grant in cycle N appears on the port in cycle N+1 and is held for exactly one cycle. The register file samples it on the following falling edge.
- Latency:
  - ALU or LINK request to port: 1 cycle when uncontested.
  - `mem_valid` to port: 2 cycles minimum (push, then grant).
- The busy bit is set from the cycle after `ld_issue` and cleared from the cycle after the MEM grant, so `hazard` deasserts in the same cycle the write appears on `rf_*`.
- Reset values (applied while `rst = 1`):
  - `rf_we = 0`, `rf_addr = 0`, `rf_wdata = 0`, `grant_src = 0`
  - FIFO empty, `mem_ready = 1`, `busy = 0`, `starve_cnt = 0`, `hazard = 0`
  - `alu_ready = 0`, `link_ready = 0`; requests are ignored.
- Reset mid-operation discards all queued loads and busy bits. No write issues in the cycle after reset is asserted.
- Pointers wrap modulo `MQ_DEPTH`; full/empty are distinguished by an extra pointer bit.

## Test plan
- ALU only: `alu_rd = 5`, `alu_data = 0x1234`, `alu_lui = 1` -> next cycle `rf_we = 1`, `rf_addr = 5`, `rf_wdata = 0x12340000`, `grant_src = 1`.
- ALU and LINK in the same cycle, `link_pc = 0x100` -> LINK wins: `rf_addr = 31`, `rf_wdata = 0x104`. ALU is written the cycle after.
- Starvation: MEM queue kept non-empty plus ALU valid continuously -> ALU is granted on its 5th requesting cycle (`STARVE_MAX = 4`), then `starve_cnt = 0`.
- Load scoreboard: `ld_issue`, `ld_rd = 7`; decode `rs = 7` -> `hazard = 1` until the cycle `rf_addr = 7` from MEM appears, where `hazard = 0`. `ld_rd = 0` never raises `hazard`.
- FIFO full: 3 back-to-back `mem_valid` while LINK holds the port -> 2 accepted, `mem_ready = 0` on the 3rd. The 3rd is accepted after the first pop, and all writes emerge in order.
- Reset asserted with 2 queued loads and busy bits set -> after reset, FIFO empty, `hazard = 0`, no MEM write emerges.
